// File: rtl/ex_1.sv
// ex_1: 16-lamp "flick" light sequencer.
// A flick pulse in idle starts a fixed on/off sweep across the lamp bank.
// Y moves one lamp per clock; there is no prescaler.
// On the edge where Y reaches a phase end pattern, only the state changes
// and Y holds. The next phase takes its first step on the following edge.
// Two kickback points (Y==16'h001F in ST2 and in ST4) sample flick and
// return to the preceding turn-on phase when it is high.
// The state register is brought out on `state` for observation.
// reset_n is active-HIGH; the name is historical.
module ex_1 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flick,
  output logic [15:0] Y,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST0 = 3'd0,
    ST1 = 3'd1,
    ST2 = 3'd2,
    ST3 = 3'd3,
    ST4 = 3'd4,
    ST5 = 3'd5,
    ST6 = 3'd6
  } state_t;

  localparam logic [15:0] ALL_ON   = 16'hFFFF;
  localparam logic [15:0] KICK_PT  = 16'h001F;
  localparam logic [15:0] MID_TOP  = 16'h07FF;
  localparam logic [15:0] LOW_TOP  = 16'h003F;
  localparam logic [15:0] ALL_OFF  = 16'h0000;

  state_t      st;
  logic [15:0] y_on;
  logic [15:0] y_off;

  // Next lamp patterns for a shift-on and a shift-off step.
  always_comb begin
    y_on  = {Y[14:0], 1'b1};
    y_off = {1'b0, Y[15:1]};
  end

  assign state = st;

  // Sequencer: state and lamp vector update together. Phase ends hold Y.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      st <= ST0;
      Y  <= ALL_OFF;
    end else begin
      case (st)
        ST0: begin
          Y <= ALL_OFF;
          if (flick) st <= ST1;
        end
        ST1: begin
          if (Y == ALL_ON) st <= ST2;
          else             Y  <= y_on;
        end
        ST2: begin
          if (Y == KICK_PT) st <= flick ? ST1 : ST3;
          else              Y  <= y_off;
        end
        ST3: begin
          if (Y == MID_TOP) st <= ST4;
          else              Y  <= y_on;
        end
        ST4: begin
          if (Y == KICK_PT && flick) st <= ST3;
          else if (Y == ALL_OFF)     st <= ST5;
          else                       Y  <= y_off;
        end
        ST5: begin
          if (Y == LOW_TOP) st <= ST6;
          else              Y  <= y_on;
        end
        ST6: begin
          if (Y == ALL_OFF) st <= ST0;
          else              Y  <= y_off;
        end
        default: begin
          st <= ST0;
          Y  <= ALL_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_1.sv
// Bench for ex_1. The expected lamp trace is built phase by phase from the
// documented sweep (step counts per phase), alongside the flick stimulus.
// The queues are then replayed one clock at a time.
module tb_ex_1;

  logic        clk;
  logic        reset_n;
  logic        flick;
  logic [15:0] Y;
  logic [2:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  logic [18:0] exp_q[$];   // {state, Y} expected after each edge
  logic        stim_q[$];  // flick driven before each edge

  logic [15:0] y_m;        // model lamp vector while building traces
  logic        fl;         // flick level attached to pushed steps

  ex_1 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flick   (flick),
    .Y       (Y),
    .state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- trace builders ----------------
  task automatic push(input logic [2:0] st);
    stim_q.push_back(fl);
    exp_q.push_back({st, y_m});
  endtask

  task automatic end_edge(input logic [2:0] st);
    push(st);
  endtask

  task automatic on_steps(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      y_m = {y_m[14:0], 1'b1};
      push(st);
    end
  endtask

  task automatic off_steps(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      y_m = {1'b0, y_m[15:1]};
      push(st);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(3'd0);
  endtask

  // ST3 (from 001F) through the return to ST0, no kickbacks.
  task automatic tail_from_st3();
    on_steps(3'd3, 6);  end_edge(3'd4);
    off_steps(3'd4, 11); end_edge(3'd5);
    on_steps(3'd5, 6);  end_edge(3'd6);
    off_steps(3'd6, 6); end_edge(3'd0);
  endtask

  // ---------------- driver / checker ----------------
  task automatic chk(input string tag, input logic [2:0] exp_st,
                     input logic [15:0] exp_y);
    vectors++;
    assert (Y === exp_y && state === exp_st) else begin
      miscompares++;
      $error("FAIL %s: got state=%0d Y=%h, want state=%0d Y=%h",
             tag, state, Y, exp_st, exp_y);
    end
  endtask

  task automatic run_queue(input string tag);
    logic [18:0] e;
    while (exp_q.size() > 0) begin
      flick = stim_q.pop_front();
      e     = exp_q.pop_front();
      @(posedge clk);
      #1;
      chk(tag, e[18:16], e[15:0]);
    end
    flick = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b1;
    flick   = 1'b0;
    y_m     = 16'h0000;
    fl      = 1'b0;
    #1;
    chk("reset_initial", 3'd0, 16'h0000);

    // 1: reset held with flick toggling, then idle after release
    for (int i = 0; i < 4; i++) begin
      fl = i[0];
      push(3'd0);
    end
    run_queue("reset_hold");
    reset_n = 1'b0;
    fl = 1'b0;
    idle(20);
    run_queue("idle_after_reset");

    // 2: nominal sequence, flick high for 4 clocks
    y_m = 16'h0000;
    fl = 1'b1; end_edge(3'd1); on_steps(3'd1, 3);
    fl = 1'b0; on_steps(3'd1, 13); end_edge(3'd2);
    off_steps(3'd2, 11); end_edge(3'd3);
    tail_from_st3();
    idle(5);
    run_queue("nominal");

    // 3: kickback from ST2 to ST1
    y_m = 16'h0000;
    fl = 1'b1; end_edge(3'd1); on_steps(3'd1, 3);
    fl = 1'b0; on_steps(3'd1, 13); end_edge(3'd2);
    off_steps(3'd2, 10);                       // Y = 003F
    fl = 1'b1; off_steps(3'd2, 1);             // Y = 001F
    end_edge(3'd1);                            // kickback
    on_steps(3'd1, 2);
    fl = 1'b0; on_steps(3'd1, 9); end_edge(3'd2);
    off_steps(3'd2, 11); end_edge(3'd3);
    tail_from_st3();
    idle(3);
    run_queue("kick_st2");

    // 4: kickback from ST4 to ST3
    y_m = 16'h0000;
    fl = 1'b1; end_edge(3'd1);
    fl = 1'b0; on_steps(3'd1, 16); end_edge(3'd2);
    off_steps(3'd2, 11); end_edge(3'd3);
    on_steps(3'd3, 6); end_edge(3'd4);
    off_steps(3'd4, 5);                        // Y = 003F
    fl = 1'b1; off_steps(3'd4, 1);             // Y = 001F
    end_edge(3'd3);                            // kickback
    on_steps(3'd3, 2);
    fl = 1'b0; on_steps(3'd3, 4); end_edge(3'd4);
    off_steps(3'd4, 11); end_edge(3'd5);
    on_steps(3'd5, 6); end_edge(3'd6);
    off_steps(3'd6, 6); end_edge(3'd0);
    idle(3);
    run_queue("kick_st4");

    // 6: flick only in non-kickback phases; trace matches nominal
    y_m = 16'h0000;
    fl = 1'b1; end_edge(3'd1); on_steps(3'd1, 5);
    fl = 1'b0; on_steps(3'd1, 11); end_edge(3'd2);
    off_steps(3'd2, 11); end_edge(3'd3);
    on_steps(3'd3, 2);
    fl = 1'b1; on_steps(3'd3, 3);
    fl = 1'b0; on_steps(3'd3, 1); end_edge(3'd4);
    off_steps(3'd4, 11); end_edge(3'd5);
    fl = 1'b1; on_steps(3'd5, 6);
    fl = 1'b0; end_edge(3'd6);
    fl = 1'b1; off_steps(3'd6, 5);
    fl = 1'b0; off_steps(3'd6, 1); end_edge(3'd0);
    idle(3);
    run_queue("flick_ignored");

    // 5: asynchronous reset in the middle of ST3
    y_m = 16'h0000;
    fl = 1'b1; end_edge(3'd1);
    fl = 1'b0; on_steps(3'd1, 16); end_edge(3'd2);
    off_steps(3'd2, 11); end_edge(3'd3);
    on_steps(3'd3, 3);                         // Y = 00FF
    run_queue("pre_async_reset");
    #3;
    reset_n = 1'b1;
    #1;
    chk("async_reset", 3'd0, 16'h0000);
    y_m = 16'h0000;
    fl = 1'b1; idle(2);
    run_queue("reset_held_flick");
    reset_n = 1'b0;
    fl = 1'b0; idle(3);
    run_queue("after_async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
